// File: rtl/pe_pad_seq_pkg.sv
// Shared types and constants for the PE scratchpad loop sequencer.
// Holds the sequencer state encoding and the config legality check.
package pe_pad_seq_pkg;

  localparam int PAD_SIZE = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN,
    ST_POP,
    ST_DONE
  } pad_seq_state_e;

  // A window must fit the IF pad and all filters' weights must fit the weight pad.
  function automatic logic cfg_illegal(input int if_len, input int pm, input int num_out,
                                       input int pad_size, input int w_addr_wd);
    return (if_len == 0) || (pm == 0) || (num_out == 0) || (if_len > pad_size) ||
           (pm * if_len > (1 << w_addr_wd));
  endfunction

endpackage

// File: rtl/pe_pad_seq_pad_wrap_cnt.sv
// Modulo-N up counter with clear and load; the step is added with a single
// conditional subtraction, so both q and step must stay below N.
module pad_wrap_cnt #(
  parameter int N  = 12,
  parameter int W  = 4,
  parameter int SW = 4
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_clr,
  input  logic          i_ld,
  input  logic [W-1:0]  i_ld_val,
  input  logic          i_inc,
  input  logic [SW-1:0] i_step,
  output logic [W-1:0]  o_q
);

  localparam int SumW = ((W > SW) ? W : SW) + 1;

  logic [SumW-1:0] sum;
  logic [W-1:0]    nxt;

  assign sum = SumW'(o_q) + SumW'(i_step);
  assign nxt = (sum >= SumW'(N)) ? W'(sum - SumW'(N)) : W'(sum);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)    o_q <= '0;
    else if (i_clr) o_q <= '0;
    else if (i_ld)  o_q <= i_ld_val;
    else if (i_inc) o_q <= nxt;
  end

endmodule

// File: rtl/pe_pad_seq.sv
// Loop sequencer for one PE: walks filters x window entries per output pixel,
// issuing IF/weight pad reads, then pops consumed IF entries and advances the base.
module pe_pad_seq
  import pe_pad_seq_pkg::*;
#(
  parameter int PadSize  = PAD_SIZE,
  parameter int AddrWd   = 4,
  parameter int ConfDWd  = 4,
  parameter int PConfDWd = 3,
  parameter int WAddrWd  = 8
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_clear,
  input  logic                i_start,
  input  logic [ConfDWd-1:0]  i_IFLen,
  input  logic [ConfDWd-1:0]  i_PopU,
  input  logic [PConfDWd-1:0] i_Pm,
  input  logic [ConfDWd-1:0]  i_NumOut,
  input  logic [AddrWd:0]     i_ifCnt,
  input  logic                i_stall,
  output logic                o_rdEn,
  output logic [AddrWd-1:0]   o_ifAddr,
  output logic [WAddrWd-1:0]  o_wAddr,
  output logic [PConfDWd-1:0] o_filt,
  output logic                o_psumFirst,
  output logic                o_psumLast,
  output logic                o_pop,
  output logic                o_nxtRow,
  output logic                o_done,
  output logic                o_busy,
  output logic                o_err
);

  pad_seq_state_e state_q;

  logic [ConfDWd-1:0]  if_len_q, pop_u_q, num_out_q, k_q, pix_q;
  logic [PConfDWd-1:0] pm_q, m_q;
  logic [WAddrWd-1:0]  w_cnt_q;
  logic [AddrWd-1:0]   base_q, if_ptr_q;
  logic                run_rd, last_k, last_m, last_pix, data_ok, cfg_bad;

  assign run_rd   = (state_q == ST_RUN) && !i_stall;
  assign last_k   = (k_q == if_len_q - ConfDWd'(1));
  assign last_m   = (m_q == pm_q - PConfDWd'(1));
  assign last_pix = (pix_q == num_out_q - ConfDWd'(1));
  assign data_ok  = int'(i_ifCnt) >= int'(if_len_q);
  assign cfg_bad  = cfg_illegal(int'(i_IFLen), int'(i_Pm), int'(i_NumOut), PadSize, WAddrWd);

  pad_wrap_cnt #(.N(PadSize), .W(AddrWd), .SW(ConfDWd)) u_base (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_clr    (i_clear || (state_q == ST_DONE)),
    .i_ld     (1'b0),
    .i_ld_val ('0),
    .i_inc    (state_q == ST_POP),
    .i_step   (pop_u_q),
    .o_q      (base_q)
  );

  // Tracks (base + k) mod PadSize; reloaded from base at the start of every window.
  pad_wrap_cnt #(.N(PadSize), .W(AddrWd), .SW(1)) u_if_ptr (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_clr    (i_clear || (state_q == ST_DONE)),
    .i_ld     ((state_q == ST_WAIT) || (run_rd && last_k)),
    .i_ld_val (base_q),
    .i_inc    (run_rd && !last_k),
    .i_step   (1'b1),
    .o_q      (if_ptr_q)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      if_len_q    <= '0;
      pop_u_q     <= '0;
      pm_q        <= '0;
      num_out_q   <= '0;
      k_q         <= '0;
      m_q         <= '0;
      pix_q       <= '0;
      w_cnt_q     <= '0;
      o_rdEn      <= 1'b0;
      o_ifAddr    <= '0;
      o_wAddr     <= '0;
      o_filt      <= '0;
      o_psumFirst <= 1'b0;
      o_psumLast  <= 1'b0;
      o_pop       <= 1'b0;
      o_nxtRow    <= 1'b0;
      o_done      <= 1'b0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else if (i_clear) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      m_q         <= '0;
      pix_q       <= '0;
      w_cnt_q     <= '0;
      o_rdEn      <= 1'b0;
      o_ifAddr    <= '0;
      o_wAddr     <= '0;
      o_filt      <= '0;
      o_psumFirst <= 1'b0;
      o_psumLast  <= 1'b0;
      o_pop       <= 1'b0;
      o_nxtRow    <= 1'b0;
      o_done      <= 1'b0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_rdEn      <= 1'b0;
      o_psumFirst <= 1'b0;
      o_psumLast  <= 1'b0;
      o_pop       <= 1'b0;
      o_nxtRow    <= 1'b0;
      o_done      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if_len_q  <= i_IFLen;
            pop_u_q   <= i_PopU;
            pm_q      <= i_Pm;
            num_out_q <= i_NumOut;
            o_err     <= cfg_bad;
            o_busy    <= 1'b1;
            state_q   <= cfg_bad ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          k_q     <= '0;
          m_q     <= '0;
          w_cnt_q <= '0;
          if (data_ok && !i_stall) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!i_stall) begin
            o_rdEn      <= 1'b1;
            o_ifAddr    <= if_ptr_q;
            o_wAddr     <= w_cnt_q;
            o_filt      <= m_q;
            o_psumFirst <= (k_q == '0);
            o_psumLast  <= last_k;
            w_cnt_q     <= w_cnt_q + WAddrWd'(1);
            if (last_k) begin
              k_q <= '0;
              if (last_m) begin
                m_q     <= '0;
                state_q <= ST_POP;
              end else begin
                m_q <= m_q + PConfDWd'(1);
              end
            end else begin
              k_q <= k_q + ConfDWd'(1);
            end
          end
        end
        ST_POP: begin
          o_pop <= 1'b1;
          if (last_pix) begin
            state_q <= ST_DONE;
          end else begin
            pix_q   <= pix_q + ConfDWd'(1);
            state_q <= ST_WAIT;
          end
        end
        ST_DONE: begin
          o_done   <= 1'b1;
          o_nxtRow <= !o_err;
          o_busy   <= 1'b0;
          pix_q    <= '0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
